regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL expose parameter XLEN, default 32, data width in bits.
REQ-002 SHALL expose parameter NREG, default 32, register count; power of two, 2..64.
REQ-003 SHALL expose parameter BYPASS, default 1; 1 forwards same-cycle write data to reads, 0 does not.
REQ-004 SHALL derive AW = log2(NREG) internally; all register addresses below are AW bits wide.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports ra1, ra2  input  AW  read addresses.
REQ-008 SHALL have ports ren1, ren2  input  1  read-operand-used flags, for hazard checking only.
REQ-009 SHALL have ports rd1, rd2  output  XLEN  read data.
REQ-010 SHALL have ports we0, we1  input  1  write enables, writeback ports 0 and 1.
REQ-011 SHALL have ports wa0, wa1  input  AW  write addresses.
REQ-012 SHALL have ports wd0, wd1  input  XLEN  write data.
REQ-013 SHALL have port issue_valid  input  1  request to reserve destination issue_wa.
REQ-014 SHALL have port issue_wa  input  AW  destination register being reserved.
REQ-015 SHALL have port issue_ready  output  1  reservation accepted this cycle.
REQ-016 SHALL have port flush  input  1  synchronous clear of all reservations.
REQ-017 SHALL have port hazard  output  1  a used operand is still reserved.

Function
REQ-018 SHALL read register 0 as all-zero, ignore writes to it, and never mark it busy.
REQ-019 SHALL, on a clock edge with weN=1 and waN!=0, store wdN into register waN.
REQ-020 SHALL, when we0 and we1 target the same nonzero address in one cycle, store wd1 (port 1 has priority).
REQ-021 SHALL drive rd1/rd2 combinationally from the stored array when BYPASS=0; written data is visible the cycle after the write edge.
REQ-022 SHALL, when BYPASS=1 and raX!=0 matches an active write address, drive rdX with that write's data in the same cycle; port 1 data takes priority over port 0.
REQ-023 SHALL keep one busy bit per register (scoreboard).
REQ-024 SHALL, on an edge where an active write targets a nonzero address, clear that register's busy bit.
REQ-025 SHALL, on an edge where issue_valid=1, issue_ready=1 and issue_wa!=0, set busy[issue_wa].
REQ-026 SHALL let the set win when a set and a clear hit the same address on one edge (the newer producer is in flight).
REQ-027 SHALL assert operand busyX = renX and raX!=0 and busy[raX], except with BYPASS=1 a same-cycle write to raX masks busyX.
REQ-028 SHALL drive hazard = busy1 or busy2, combinationally.
REQ-029 SHALL drive issue_ready = not hazard and not flush; issue_valid while issue_ready=0 SHALL change no state.
REQ-030 SHALL, on an edge with flush=1, clear all busy bits; register contents are unchanged, writes on that edge still occur, and any issue on that edge is dropped.

Reset
REQ-031 SHALL, while rst_n=0 and regardless of clk, clear all registers to 0 and all busy bits to 0.
REQ-032 SHALL, during reset, drive rd1=rd2=0 and hazard=0; issue_ready follows REQ-029 (1 when flush=0).
REQ-033 SHALL, on reset asserted mid-operation, discard any pending write or issue on the same edge; reset dominates.
REQ-034 SHALL resume normal updates on the first rising clk edge after rst_n returns high.

Verification
REQ-035 SHALL cover: write x5=0xDEADBEEF via port 0, next cycle ra1=5 -> rd1=0xDEADBEEF; write x0=0x1234 then ra2=0 -> rd2=0.
REQ-036 SHALL cover: we0/we1 both to x7 with 0x11/0x22 -> x7=0x22; with BYPASS=1, same cycle ra1=7 -> rd1=0x22; with BYPASS=0 -> old value.
REQ-037 SHALL cover: issue x3, next cycle ren1=1, ra1=3 -> hazard=1, issue_ready=0; we0 to x3 with 0x99 -> hazard=0 same cycle (BYPASS=1), rd1=0x99.
REQ-038 SHALL cover: same edge issue x4 and writeback x4 -> busy[4]=1 after the edge.
REQ-039 SHALL cover: busy x2 and x9, then flush=1 with issue_valid on x6 -> all busy bits 0, x6 not busy, register contents intact.
REQ-040 SHALL cover: rst_n pulled low asynchronously between edges with registers loaded and busy set -> rd1=rd2=0, hazard=0 immediately, and the state stays cleared after release.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: two-read / two-write register file with a per-register busy
// scoreboard for issue-time hazard detection.
//
// Parameters
//   XLEN   data width
//   NREG   register count (power of two, 2..64); x0 reads as zero
//   BYPASS 1: same-cycle write data is forwarded to reads and masks hazards
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ra1/ra2, ren1/ren2  read addresses and operand-used flags
//   rd1/rd2             combinational read data
//   we0/we1, wa0/wa1,   writeback ports 0 and 1 (port 1 wins on collision)
//   wd0/wd1
//   issue_valid/_wa     destination reservation request
//   issue_ready         reservation accepted this cycle
//   flush               clears every reservation on the next edge
//   hazard              a used operand is still reserved
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(NREG)-1:0]   ra1,
  input  logic [$clog2(NREG)-1:0]   ra2,
  input  logic                      ren1,
  input  logic                      ren2,
  output logic [XLEN-1:0]           rd1,
  output logic [XLEN-1:0]           rd2,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [$clog2(NREG)-1:0]   wa0,
  input  logic [$clog2(NREG)-1:0]   wa1,
  input  logic [XLEN-1:0]           wd0,
  input  logic [XLEN-1:0]           wd1,
  input  logic                      issue_valid,
  input  logic [$clog2(NREG)-1:0]   issue_wa,
  output logic                      issue_ready,
  input  logic                      flush,
  output logic                      hazard
);

  localparam int unsigned AW  = $clog2(NREG);
  localparam bit          BYP = (BYPASS != 0);

  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic wr0_act, wr1_act;
  logic hit0_1, hit1_1, hit0_2, hit1_2;
  logic busy1, busy2;
  logic issue_fire;

  // Writes to x0 are dropped outright
  assign wr0_act = we0 && (wa0 != AW'(0));
  assign wr1_act = we1 && (wa1 != AW'(0));

  // Forwarding matches; an active write never targets x0, so a hit implies raX!=0.
  // Gated by rst_n so reads stay zero while reset is held.
  assign hit0_1 = BYP && rst_n && wr0_act && (wa0 == ra1);
  assign hit1_1 = BYP && rst_n && wr1_act && (wa1 == ra1);
  assign hit0_2 = BYP && rst_n && wr0_act && (wa0 == ra2);
  assign hit1_2 = BYP && rst_n && wr1_act && (wa1 == ra2);

  // Read port 1: array, then port 0 forward, then port 1 forward (highest priority)
  always_comb begin
    rd1 = rf_q[ra1];
    if (ra1 == AW'(0)) rd1 = '0;
    if (hit0_1)        rd1 = wd0;
    if (hit1_1)        rd1 = wd1;
  end

  // Read port 2, same priority order
  always_comb begin
    rd2 = rf_q[ra2];
    if (ra2 == AW'(0)) rd2 = '0;
    if (hit0_2)        rd2 = wd0;
    if (hit1_2)        rd2 = wd1;
  end

  // Operand hazards; a forwarded write supplies the value so the operand is not stalled
  assign busy1 = ren1 && (ra1 != AW'(0)) && busy_q[ra1] && !(hit0_1 || hit1_1);
  assign busy2 = ren2 && (ra2 != AW'(0)) && busy_q[ra2] && !(hit0_2 || hit1_2);

  assign hazard      = busy1 || busy2;
  assign issue_ready = !hazard && !flush;
  assign issue_fire  = issue_valid && issue_ready && (issue_wa != AW'(0));

  // Register array; later assignment gives port 1 priority on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      if (wr0_act) rf_q[wa0] <= wd0;
      if (wr1_act) rf_q[wa1] <= wd1;
    end
  end

  // Scoreboard next state: clears first, then flush or set (set beats a same-edge clear)
  always_comb begin
    busy_d = busy_q;
    if (wr0_act) busy_d[wa0] = 1'b0;
    if (wr1_act) busy_d[wa1] = 1'b0;
    if (flush)           busy_d = '0;
    else if (issue_fire) busy_d[issue_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule
